psram_fetch_sched: RTL and testbench

Scanout prefetch scheduler sitting between the HDMI line buffer and the read port of `psram_arb`. On each frame start it walks the framebuffer in fixed-size read bursts. It issues one arbiter read request per burst, but only when the line buffer has room for the whole burst. It forwards returned beats into the line buffer and flags line and frame completion to the video timing logic.

---
 rtl/psram_pkg.sv | 14 +
 rtl/fetch_credit_ctr.sv | 54 +++++
 rtl/psram_fetch_sched.sv | 175 +++++++++++++++++
 tb/tb_psram_fetch_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Constants and FSM state type shared by the PSRAM arbiter and the scanout fetch scheduler.
package psram_pkg;

  localparam int unsigned PsramBeats = 4;
  localparam int unsigned PsramAddrW = 21;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StAdv
  } fetch_state_e;

endpackage

// File: rtl/fetch_credit_ctr.sv
// Line-buffer credit counter: +1 per pop, +1 per swallowed beat, -BEATS per grant.
// Saturates at FIFO_BEATS; an unmatched pop at full is dropped and latches err.
module fetch_credit_ctr #(
  parameter int unsigned FIFO_BEATS = 32,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned CW         = $clog2(FIFO_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pop,
  input  logic          take,
  input  logic          give,
  output logic [CW-1:0] credits,
  output logic          err
);

  localparam logic [CW:0] Full  = (CW + 1)'(FIFO_BEATS);
  localparam logic [CW:0] Burst = (CW + 1)'(BEATS);

  logic          full;
  logic          pop_ok;
  logic          err_set;
  logic [CW:0]   sum;
  logic [CW-1:0] credits_d;

  assign full = ({1'b0, credits} == Full);
  // A pop at full is legal only when a grant consumes credits in the same cycle.
  assign pop_ok  = pop && (!full || take);
  assign err_set = pop && full && !take;

  always_comb begin
    sum = {1'b0, credits} + (CW + 1)'(pop_ok) + (CW + 1)'(give);
    if (take) begin
      sum = sum - Burst;
    end
    if (sum > Full) begin
      sum = Full;
    end
    credits_d = sum[CW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(FIFO_BEATS);
      err     <= 1'b0;
    end else begin
      credits <= credits_d;
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_fetch_sched.sv
// Scanout prefetch scheduler: walks the framebuffer in fixed bursts, issuing one arbiter
// read per burst when the line buffer has room, and forwards returned beats to the buffer.
module psram_fetch_sched
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_W      = PsramAddrW,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BEATS       = PsramBeats,
  parameter int unsigned ADDR_STEP   = 16,
  parameter int unsigned LINE_BURSTS = 40,
  parameter int unsigned LINES       = 240,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FIFO_BEATS  = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_frame_start,
  input  logic                              i_fifo_pop,
  output logic                              o_read_req,
  input  logic                              i_read_gnt,
  output logic [ADDR_W-1:0]                 o_read_addr,
  input  logic [DATA_W-1:0]                 i_read_data,
  input  logic                              i_read_data_valid,
  output logic                              o_wr_en,
  output logic [DATA_W-1:0]                 o_wr_data,
  output logic                              o_line_done,
  output logic                              o_frame_done,
  output logic [$clog2(FIFO_BEATS+1)-1:0]   o_credits,
  output logic                              o_err
);

  localparam int unsigned CW  = $clog2(FIFO_BEATS + 1);
  localparam int unsigned BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LBW = (LINE_BURSTS > 1) ? $clog2(LINE_BURSTS) : 1;
  localparam int unsigned LW  = (LINES > 1) ? $clog2(LINES) : 1;

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LBW-1:0]       burst_q, burst_d;
  logic [LW-1:0]        line_q, line_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 pend_q, pend_d;
  logic                 req_d;
  logic                 wr_en_d;
  logic [DATA_W-1:0]    wr_data_d;
  logic                 take;
  logic                 give;
  logic                 restart;
  logic                 swallow;

  assign o_read_addr  = addr_q;
  assign o_line_done  = (state_q == StAdv) && (burst_q == LBW'(LINE_BURSTS - 1));
  assign o_frame_done = o_line_done && (line_q == LW'(LINES - 1));
  assign swallow      = pend_q || i_frame_start;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    line_d    = line_q;
    beat_d    = beat_q;
    pend_d    = pend_q;
    req_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = o_wr_data;
    take      = 1'b0;
    give      = 1'b0;
    restart   = 1'b0;
    unique case (state_q)
      StIdle: begin
        restart = i_frame_start;
      end
      StReq: begin
        // Frame start wins over a same-cycle grant; the burst is simply not taken.
        if (i_frame_start) begin
          restart = 1'b1;
        end else if (o_read_req && i_read_gnt) begin
          take    = 1'b1;
          beat_d  = '0;
          state_d = StWait;
        end else begin
          req_d = (o_credits >= CW'(BEATS));
        end
      end
      StWait: begin
        if (i_frame_start) begin
          pend_d = 1'b1;
        end
        if (i_read_data_valid) begin
          if (swallow) begin
            give = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = i_read_data;
          end
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(BEATS - 1)) begin
            if (swallow) begin
              restart = 1'b1;
              pend_d  = 1'b0;
            end else begin
              state_d = StAdv;
            end
          end
        end
      end
      StAdv: begin
        if (i_frame_start) begin
          restart = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(ADDR_STEP);
          state_d = StReq;
          if (burst_q == LBW'(LINE_BURSTS - 1)) begin
            burst_d = '0;
            if (line_q == LW'(LINES - 1)) begin
              line_d  = '0;
              state_d = StIdle;
            end else begin
              line_d = line_q + LW'(1);
            end
          end else begin
            burst_d = burst_q + LBW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (restart) begin
      state_d = StReq;
      addr_d  = ADDR_W'(BASE_ADDR);
      burst_d = '0;
      line_d  = '0;
      beat_d  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      burst_q    <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      o_read_req <= 1'b0;
      o_wr_en    <= 1'b0;
      o_wr_data  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
      o_read_req <= req_d;
      o_wr_en    <= wr_en_d;
      o_wr_data  <= wr_data_d;
    end
  end

  fetch_credit_ctr #(
    .FIFO_BEATS (FIFO_BEATS),
    .BEATS      (BEATS),
    .CW         (CW)
  ) u_credit (
    .clk     (i_clk),
    .rst     (i_rst),
    .pop     (i_fifo_pop),
    .take    (take),
    .give    (give),
    .credits (o_credits),
    .err     (o_err)
  );

endmodule

// File: tb/tb_psram_fetch_sched.sv
// Scoreboard bench for psram_fetch_sched with small frame geometry (2 lines x 2 bursts x 4 beats).
module tb_psram_fetch_sched;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 64;
  localparam int unsigned FB = 8;
  localparam int unsigned CW = $clog2(FB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_frame_start = 1'b0;
  logic          i_fifo_pop = 1'b0;
  logic          i_read_gnt = 1'b0;
  logic [DW-1:0] i_read_data = '0;
  logic          i_read_data_valid = 1'b0;
  logic          o_read_req;
  logic [AW-1:0] o_read_addr;
  logic          o_wr_en;
  logic [DW-1:0] o_wr_data;
  logic          o_line_done;
  logic          o_frame_done;
  logic [CW-1:0] o_credits;
  logic          o_err;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int            line_at[$];
  int            wr_cnt = 0;
  int            line_cnt = 0;
  int            frame_cnt = 0;
  int            buffered = 0;
  int            man_pops = 0;
  bit            pop_auto = 1'b0;
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  psram_fetch_sched #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BEATS       (4),
    .ADDR_STEP   (16),
    .LINE_BURSTS (2),
    .LINES       (2),
    .BASE_ADDR   (32'h100),
    .FIFO_BEATS  (FB)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_frame_start     (i_frame_start),
    .i_fifo_pop        (i_fifo_pop),
    .o_read_req        (o_read_req),
    .i_read_gnt        (i_read_gnt),
    .o_read_addr       (o_read_addr),
    .i_read_data       (i_read_data),
    .i_read_data_valid (i_read_data_valid),
    .o_wr_en           (o_wr_en),
    .o_wr_data         (o_wr_data),
    .o_line_done       (o_line_done),
    .o_frame_done      (o_frame_done),
    .o_credits         (o_credits),
    .o_err             (o_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor and line-buffer consumer, both away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wr_en) begin
        wr_cnt++;
        buffered++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", o_wr_en, 1'b0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wr_data", o_wr_data, mon_exp);
        end
      end
      if (o_line_done) begin
        line_cnt++;
        line_at.push_back(wr_cnt);
        check("done_align", o_wr_en, 1'b1);
      end
      if (o_frame_done) begin
        frame_cnt++;
      end
    end
    i_fifo_pop = 1'b0;
    if (man_pops > 0) begin
      i_fifo_pop = 1'b1;
      man_pops--;
    end else if (pop_auto && buffered > 0) begin
      i_fifo_pop = 1'b1;
      buffered--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_frame_start = 1'b0;
    i_read_gnt = 1'b0;
    i_read_data_valid = 1'b0;
    man_pops = 0;
    pop_auto = 1'b0;
    #1;
    exp_q.delete();
    line_at.delete();
    buffered = 0;
    wr_cnt = 0;
    line_cnt = 0;
    frame_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic frame_pulse();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  task automatic wait_req(input logic [AW-1:0] exp_addr, input string tag);
    int n = 0;
    while (!o_read_req && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"}, o_read_req, 1'b1);
    check({tag, "_addr"}, o_read_addr, exp_addr);
  endtask

  task automatic grant(input int dly, input bit with_pop);
    logic [AW-1:0] a = o_read_addr;
    for (int i = 0; i < dly; i++) begin
      tick();
      check("req_hold", o_read_req, 1'b1);
      check("addr_hold", o_read_addr, a);
    end
    i_read_gnt = 1'b1;
    if (with_pop) man_pops++;
    tick();
    i_read_gnt = 1'b0;
    check("req_drop", o_read_req, 1'b0);
  endtask

  task automatic beats(input int n, input bit expect_wr);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom(), $urandom()};
      i_read_data = d;
      i_read_data_valid = 1'b1;
      if (expect_wr) exp_q.push_back(d);
      tick();
    end
    i_read_data_valid = 1'b0;
  endtask

  initial begin
    int w0;
    // Reset values, checked right after asynchronous assertion and before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_req", o_read_req, 1'b0);
    check("rst_wr", o_wr_en, 1'b0);
    check("rst_credits", o_credits, CW'(FB));
    check("rst_err", o_err, 1'b0);
    check("rst_done", {o_line_done, o_frame_done}, 2'b00);
    do_reset();

    // Reset mid-burst drops the burst; later beats are ignored.
    frame_pulse();
    wait_req(21'h100, "rmid");
    grant(1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rmid_req", o_read_req, 1'b0);
    check("rmid_credits", o_credits, CW'(FB));
    check("rmid_addr", o_read_addr, 0);
    tick();
    rst = 1'b0;
    w0 = wr_cnt;
    beats(4, 1'b0);
    tick();
    tick();
    check("rmid_nowr", wr_cnt - w0, 0);
    check("rmid_idle", o_read_req, 1'b0);

    // Full frame with consumer keeping up.
    do_reset();
    pop_auto = 1'b1;
    frame_pulse();
    for (int b = 0; b < 4; b++) begin
      wait_req(AW'(32'h100 + 16 * b), "frame");
      grant(2, 1'b0);
      beats(4, 1'b1);
    end
    repeat (10) tick();
    check("frame_wr_cnt", wr_cnt, 16);
    check("frame_line_cnt", line_cnt, 2);
    if (line_at.size() == 2) begin
      check("line_done_0", line_at[0], 8);
      check("line_done_1", line_at[1], 16);
    end
    check("frame_done_cnt", frame_cnt, 1);
    check("frame_idle", o_read_req, 1'b0);
    check("frame_credits", o_credits, CW'(FB));
    check("frame_exp_left", exp_q.size(), 0);
    frame_pulse();
    wait_req(21'h100, "again");

    // Credit stall without pops.
    do_reset();
    frame_pulse();
    wait_req(21'h100, "stall0");
    grant(2, 1'b0);
    beats(4, 1'b1);
    wait_req(21'h110, "stall1");
    grant(2, 1'b0);
    beats(4, 1'b1);
    repeat (4) tick();
    check("stall_credits0", o_credits, 0);
    check("stall_req0", o_read_req, 1'b0);
    man_pops = 3;
    repeat (5) tick();
    check("stall_credits3", o_credits, 3);
    check("stall_req3", o_read_req, 1'b0);
    man_pops = 1;
    tick();
    check("stall_credits4", o_credits, 4);
    check("stall_req_pre", o_read_req, 1'b0);
    tick();
    check("stall_req4", o_read_req, 1'b1);
    check("stall_addr4", o_read_addr, 21'h120);

    // Grant and pop in the same cycle.
    do_reset();
    frame_pulse();
    wait_req(21'h100, "same");
    check("same_credits8", o_credits, CW'(FB));
    grant(1, 1'b1);
    check("same_credits5", o_credits, 5);
    check("same_err", o_err, 1'b0);
    beats(4, 1'b1);
    repeat (3) tick();

    // Restart while waiting for beats.
    do_reset();
    pop_auto = 1'b1;
    frame_pulse();
    wait_req(21'h100, "rw0");
    grant(2, 1'b0);
    beats(2, 1'b1);
    frame_pulse();
    beats(2, 1'b0);
    wait_req(21'h100, "rw1");
    check("rw_wr_cnt", wr_cnt, 2);
    check("rw_line_done", line_cnt, 0);
    check("rw_frame_done", frame_cnt, 0);
    check("rw_credits", o_credits, CW'(FB));

    // Overpop is sticky until reset.
    do_reset();
    man_pops = 1;
    repeat (2) tick();
    check("over_credits", o_credits, CW'(FB));
    check("over_err", o_err, 1'b1);
    repeat (5) tick();
    check("over_err_sticky", o_err, 1'b1);
    do_reset();
    check("over_err_clr", o_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
